dm_responder: RTL and testbench

//   Responder side of the CPU data-memory port: handshaked, multi-cycle word memory.
//   The datapath drives req/memwrite/addr/wd. This block holds each request for LATENCY cycles,

---
 rtl/dm_responder.sv | 149 ++++++++++++++
 tb/tb_dm_responder.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/dm_responder.sv
// dm_responder
//   Responder side of the CPU data-memory port: a handshaked, multi-cycle
//   32-bit word memory. A request is accepted in IDLE, or in RESP when req is
//   held high. The request is then held for LATENCY cycles. After that the
//   access is performed and answered with a one-cycle ready pulse.
//
//   Parameters
//     DEPTH    number of 32-bit words; byte addresses 0 .. 4*DEPTH-1 are valid
//     LATENCY  cycles from request acceptance to ready (1..15)
//
//   Ports
//     clk       rising-edge clock
//     rst       asynchronous, active-high reset
//     req       request valid (sampled in IDLE, and in RESP for back-to-back)
//     memwrite  1 = write, 0 = read; sampled with req
//     addr      byte address; word index = addr[31:2]
//     wd        write data; sampled with req
//     be        byte-lane write strobes (only with DM_BYTE_STROBE_EN)
//     ready     one-cycle response pulse
//     rd        read data (old word for writes); held until the next response
//     err       misaligned or out-of-range address; valid while ready=1
//
//   Build option
//     DM_BYTE_STROBE_EN  when defined, writes update only lanes with be[i]=1;
//                        otherwise be is ignored and writes update all 32 bits.

module dm_responder #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        memwrite,
   input  logic [31:0] addr,
   input  logic [31:0] wd,
   input  logic [3:0]  be,
   output logic        ready,
   output logic [31:0] rd,
   output logic        err
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t        state_reg;
   logic [3:0]    cnt_reg;
   logic          memwrite_reg;
   logic [31:0]   addr_reg;
   logic [31:0]   wd_reg;
   logic          ready_reg;
   logic [31:0]   rd_reg;
   logic          err_reg;

   logic [31:0]   mem [DEPTH];
   logic [31:0]   mem_q;

   logic          commit;
   logic          addr_err;
   logic          wr_en;
   logic [3:0]    lane_en;
   logic [AW-1:0] rd_idx;
   logic [AW-1:0] wr_idx;

`ifdef DM_BYTE_STROBE_EN
   logic [3:0]    be_reg;
   assign lane_en = be_reg;
`else
   logic          unused_be;
   assign unused_be = ^be;
   assign lane_en   = 4'hF;
`endif

   assign commit   = (state_reg == BUSY) && (cnt_reg == 4'd0);
   assign addr_err = (addr_reg[1:0] != 2'b00) ||
                     ({2'b00, addr_reg[31:2]} >= 32'(DEPTH));
   assign wr_en    = commit && memwrite_reg && !addr_err;
   assign wr_idx   = addr_reg[AW+1:2];

   // The memory read runs one edge ahead of the commit. Outside BUSY the
   // index follows the live address, so a request accepted at edge k has
   // its word in mem_q from edge k onward. That covers LATENCY=1. Writes only
   // happen at commit edges, so mem_q is never stale when it is consumed.
   assign rd_idx   = (state_reg == BUSY) ? addr_reg[AW+1:2] : addr[AW+1:2];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         cnt_reg      <= 4'd0;
         memwrite_reg <= 1'b0;
         addr_reg     <= 32'd0;
         wd_reg       <= 32'd0;
`ifdef DM_BYTE_STROBE_EN
         be_reg       <= 4'd0;
`endif
         ready_reg    <= 1'b0;
         rd_reg       <= 32'd0;
         err_reg      <= 1'b0;
      end else begin
         case (state_reg)
            IDLE, RESP: begin
               ready_reg <= 1'b0;
               if (req) begin
                  memwrite_reg <= memwrite;
                  addr_reg     <= addr;
                  wd_reg       <= wd;
`ifdef DM_BYTE_STROBE_EN
                  be_reg       <= be;
`endif
                  cnt_reg      <= 4'(LATENCY - 1);
                  state_reg    <= BUSY;
               end else begin
                  state_reg    <= IDLE;
               end
            end
            BUSY: begin
               if (cnt_reg == 4'd0) begin
                  ready_reg <= 1'b1;
                  err_reg   <= addr_err;
                  rd_reg    <= addr_err ? 32'd0 : mem_q;
                  state_reg <= RESP;
               end else begin
                  cnt_reg   <= cnt_reg - 4'd1;
               end
            end
            default: begin
               ready_reg <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   // Memory array: not reset. Registered read, per-lane write.
   always_ff @(posedge clk) begin
      mem_q <= mem[rd_idx];
      for (int i = 0; i < 4; i++) begin
         if (wr_en && lane_en[i]) begin
            mem[wr_idx][8*i +: 8] <= wd_reg[8*i +: 8];
         end
      end
   end

   assign ready = ready_reg;
   assign rd    = rd_reg;
   assign err   = err_reg;

endmodule

// File: tb/tb_dm_responder.sv
module tb_dm_responder;

   localparam int DEPTH = 256;
   localparam int LAT   = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic        memwrite = 1'b0;
   logic [31:0] addr = 32'd0;
   logic [31:0] wd = 32'd0;
   logic [3:0]  be = 4'hF;
   logic        ready;
   logic [31:0] rd;
   logic        err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      logic [31:0] rd;
      logic        err;
      logic        chk_rd;
      int          cyc;
   } exp_t;

   exp_t sb[$];

   dm_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .req(req), .memwrite(memwrite), .addr(addr),
      .wd(wd), .be(be), .ready(ready), .rd(rd), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end else begin
         $display("ok   %s: %h (cycle %0d)", name, act, cyc);
      end
   endtask

   // Monitor: every ready pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (ready === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ready: got ready=1 rd=%h err=%b expected no response (cycle %0d)",
                     rd, err, cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("resp_cycle", 32'(cyc), 32'(e.cyc));
            chk("resp_err", {31'd0, err}, {31'd0, e.err});
            if (e.chk_rd) chk("resp_rd", rd, e.rd);
         end
      end
   end

   // Issue one request; the response expectation is pushed on acceptance.
   // Returns at the commit edge so the next call lands in RESP (back-to-back).
   task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, input logic [31:0] exp_rd,
                        input logic exp_err, input logic chk_rd, input logic keep);
      exp_t e;
      @(negedge clk);
      req = 1'b1; memwrite = we; addr = a; wd = d; be = b;
      @(posedge clk);
      #1;
      e.rd = exp_rd; e.err = exp_err; e.chk_rd = chk_rd; e.cyc = cyc + LAT;
      sb.push_back(e);
      if (!keep) begin
         req = 1'b0; addr = 32'hFFFF_FFFF; wd = 32'h0; memwrite = ~we;
      end
      repeat (LAT) @(posedge clk);
   endtask

   initial begin
      #100000;
      errors++;
      $display("FAIL timeout: got no finish expected finish within 100000 time units");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      // Reset is asserted before any clock edge: outputs must already be 0.
      #3;
      chk("reset_ready", {31'd0, ready}, 32'd0);
      chk("reset_rd", rd, 32'd0);
      chk("reset_err", {31'd0, err}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Write then read, read-before-write on overwrite.
      issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0);
      issue(1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
      issue(1'b1, 32'h10, 32'h0BADF00D, 4'hF, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
      issue(1'b0, 32'h10, 32'h0, 4'hF, 32'h0BADF00D, 1'b0, 1'b1, 1'b0);

      // Errors: misaligned read, out-of-range write leaves word 0 alone.
      issue(1'b0, 32'h12, 32'h0, 4'hF, 32'h0, 1'b1, 1'b1, 1'b0);
      issue(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0);
      issue(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 1'b1, 1'b0);
      issue(1'b0, 32'h0, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0);

      // Last legal word.
      issue(1'b1, 32'h3FC, 32'h13579BDF, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0);
      issue(1'b0, 32'h3FC, 32'h0, 4'hF, 32'h13579BDF, 1'b0, 1'b1, 1'b0);

      // Idle gap, then back-to-back reads with req held high.
      repeat (3) @(posedge clk);
      issue(1'b0, 32'h10, 32'h0, 4'hF, 32'h0BADF00D, 1'b0, 1'b1, 1'b1);
      issue(1'b0, 32'h0, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0, 1'b1, 1'b1);
      issue(1'b0, 32'h3FC, 32'h0, 4'hF, 32'h13579BDF, 1'b0, 1'b1, 1'b0);

      // Reset mid-BUSY aborts a write to 0x20 with no response.
      issue(1'b1, 32'h20, 32'h12345678, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      req = 1'b1; memwrite = 1'b1; addr = 32'h20; wd = 32'h5; be = 4'hF;
      @(posedge clk);
      #1 req = 1'b0;
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      repeat (6) @(posedge clk);
      issue(1'b0, 32'h20, 32'h0, 4'hF, 32'h12345678, 1'b0, 1'b1, 1'b0);

      // rd holds after the pulse; a mid-cycle reset clears it immediately.
      @(posedge clk);
      #1;
      chk("rd_held", rd, 32'h12345678);
      #3 rst = 1'b1;
      #1;
      chk("async_rst_rd", rd, 32'd0);
      chk("async_rst_ready", {31'd0, ready}, 32'd0);
      #1 rst = 1'b0;

      // Byte strobes.
      issue(1'b1, 32'h40, 32'h11223344, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0);
      issue(1'b1, 32'h40, 32'hAABBCCDD, 4'b0101, 32'h11223344, 1'b0, 1'b1, 1'b0);
`ifdef DM_BYTE_STROBE_EN
      issue(1'b0, 32'h40, 32'h0, 4'hF, 32'h11BB33DD, 1'b0, 1'b1, 1'b0);
`else
      issue(1'b0, 32'h40, 32'h0, 4'hF, 32'hAABBCCDD, 1'b0, 1'b1, 1'b0);
`endif

      repeat (5) @(posedge clk);
      #1;
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
